// File: rtl/cntseq_pkg.sv
// Shared types and defaults for the counter run-control sequencer.
// cntseq_state_t : sequencer state (IDLE, RUN, HOLD, DONE)
// CNTSEQ_N_DEF   : default prescaler width (one tick per 2^N clk cycles)
// CNTSEQ_W_DEF   : default count register width
package cntseq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } cntseq_state_t;

    localparam int CNTSEQ_N_DEF = 21;
    localparam int CNTSEQ_W_DEF = 8;
endpackage

// File: rtl/tick_gen.sv
// N-bit prescaler producing a count-enable tick without a derived clock.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - advance the prescaler (must come from registered state)
//   clr  - force the prescaler to zero on the next edge (wins over en)
//   tick - high while enabled and the prescaler sits at 2^N-1
module tick_gen
    import cntseq_pkg::*;
#(
    parameter int N = CNTSEQ_N_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    logic [N-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Decoded from the registered count and the caller's registered enable,
    // so no input reaches tick combinationally.
    assign tick = en & (&cnt);
endmodule

// File: rtl/counter_seq.sv
// Run-control sequencer for the display counter: prescaler tick, count
// register and start/stop/pause/load command handling, one-shot or
// auto-reload against a live limit.
// Optional feature macro: CNTSEQ_DOWN_EN adds the dir port (latched at start)
// for down counting; without it the counter only counts up.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - start from IDLE, restart (from reload value) in DONE
//   stop         - abort to IDLE, prescaler cleared, data kept
//   pause        - level, freezes a running count (RUN -> HOLD)
//   load         - load load_val into data and reload value (IDLE/DONE only)
//   load_val     - value for load
//   limit        - terminal count, sampled live
//   auto_reload  - 1: reload and continue at terminal, 0: one-shot
//   dir          - (CNTSEQ_DOWN_EN only) 0 up, 1 down
//   data         - count register
//   tick         - one-cycle pulse on each prescaler rollover in RUN
//   busy         - high in RUN or HOLD
//   done         - one-cycle pulse alongside the post-terminal data value
module counter_seq
    import cntseq_pkg::*;
#(
    parameter int N = CNTSEQ_N_DEF,
    parameter int W = CNTSEQ_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    input  logic         auto_reload,
`ifdef CNTSEQ_DOWN_EN
    input  logic         dir,
`endif
    output logic [W-1:0] data,
    output logic         tick,
    output logic         busy,
    output logic         done
);
    cntseq_state_t state;
    logic [W-1:0]  reload_q;
    logic [W-1:0]  data_next_step;
    logic          start_ok;
    logic          pres_clr;
    logic          at_limit;

`ifdef CNTSEQ_DOWN_EN
    logic dir_q;
    assign data_next_step = dir_q ? data - 1'b1 : data + 1'b1;
`else
    assign data_next_step = data + 1'b1;
`endif

    // A start only counts when nothing of higher priority is present.
    assign start_ok = start & ~stop & ~load & ((state == IDLE) | (state == DONE));
    assign pres_clr = stop | start_ok;
    assign at_limit = (data == limit);

    tick_gen #(.N(N)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN),
        .clr  (pres_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data     <= '0;
            reload_q <= '0;
            done     <= 1'b0;
`ifdef CNTSEQ_DOWN_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (load) begin
                            data     <= load_val;
                            reload_q <= load_val;
                        end else if (start) begin
                            state <= RUN;
                            if (state == DONE)
                                data <= reload_q;
`ifdef CNTSEQ_DOWN_EN
                            dir_q <= dir;
`endif
                        end
                    end
                    RUN: begin
                        // A tick in the pause cycle is still honoured; the
                        // one-shot terminal takes precedence over HOLD.
                        if (pause)
                            state <= HOLD;
                        if (tick) begin
                            if (at_limit) begin
                                done <= 1'b1;
                                if (auto_reload)
                                    data <= reload_q;
                                else
                                    state <= DONE;
                            end else begin
                                data <= data_next_step;
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause)
                            state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN) | (state == HOLD);
endmodule

// File: tb/tb_counter_seq.sv
module tb_counter_seq;
    localparam int N = 2;
    localparam int W = 8;
    localparam int PERIOD = 1 << N;

    logic         clk = 1'b0;
    logic         rst, start, stop, pause, load, auto_reload;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] data;
    logic         tick, busy, done;
`ifdef CNTSEQ_DOWN_EN
    logic         dir;
`endif

    always #5 clk = ~clk;

    counter_seq #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .load        (load),
        .load_val    (load_val),
        .limit       (limit),
        .auto_reload (auto_reload),
`ifdef CNTSEQ_DOWN_EN
        .dir         (dir),
`endif
        .data        (data),
        .tick        (tick),
        .busy        (busy),
        .done        (done)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_tick_seen = 0;
    int n_done_seen = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: a mode name, a cycle position inside the tick period,
    // and the counter values held as plain integers.
    string m_mode;
    int    m_phase;
    int    m_data, m_reload;
    bit    m_done, m_down;

    task automatic model_reset();
        m_mode = "IDLE"; m_phase = 0; m_data = 0; m_reload = 0;
        m_done = 0; m_down = 0;
    endtask

    function automatic bit model_tick();
        return (m_mode == "RUN") && (m_phase == PERIOD - 1);
    endfunction

    // Advance the model over one clock edge using the current inputs.
    task automatic model_next();
        bit t;
        t = model_tick();
        m_done = 0;
        if (rst) begin
            model_reset();
        end else if (stop) begin
            m_mode = "IDLE"; m_phase = 0;
        end else if (m_mode == "IDLE" || m_mode == "DONE") begin
            if (load) begin
                m_data = load_val; m_reload = load_val;
            end else if (start) begin
                if (m_mode == "DONE") m_data = m_reload;
                m_mode = "RUN"; m_phase = 0;
`ifdef CNTSEQ_DOWN_EN
                m_down = dir;
`endif
            end
        end else if (m_mode == "RUN") begin
            m_phase = (m_phase + 1) % PERIOD;
            if (pause) m_mode = "HOLD";
            if (t) begin
                if (m_data == int'(limit)) begin
                    m_done = 1;
                    if (auto_reload) m_data = m_reload;
                    else m_mode = "DONE";
                end else begin
                    m_data = (m_data + (m_down ? 255 : 1)) % 256;
                end
            end
        end else begin
            if (!pause) m_mode = "RUN";
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("data", int'(data), m_data);
        chk("tick", int'(tick), int'(model_tick()));
        chk("busy", int'(busy), int'(m_mode == "RUN" || m_mode == "HOLD"));
        chk("done", int'(done), int'(m_done));
        if (tick) n_tick_seen++;
        if (done) n_done_seen++;
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int v);
        load = 1; load_val = W'(v); cycle(); load = 0;
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; cycle(); stop = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; load = 0; auto_reload = 0;
        load_val = '0; limit = '0;
`ifdef CNTSEQ_DOWN_EN
        dir = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        rst = 0;

        // Idle after reset: nothing moves.
        repeat (20) cycle();
        chk("idle_ticks", n_tick_seen, 0);
        chk("idle_done", n_done_seen, 0);
        chk("idle_data", int'(data), 0);

        // One-shot 5..8.
        limit = 8'h08; auto_reload = 0;
        pulse_load(5);
        n_done_seen = 0;
        pulse_start();
        repeat (24) cycle();
        chk("oneshot_data", int'(data), 8);
        chk("oneshot_busy", int'(busy), 0);
        chk("oneshot_dones", n_done_seen, 1);

        // Auto-reload from DONE: two terminal passes in 40 cycles.
        auto_reload = 1;
        pulse_load(5);
        n_done_seen = 0;
        pulse_start();
        repeat (40) cycle();
        chk("auto_dones", n_done_seen, 2);
        chk("auto_busy", int'(busy), 1);
        pulse_stop();

        // Wrap-around 0xFE -> 0x01.
        auto_reload = 0; limit = 8'h01;
        pulse_load(8'hFE);
        n_done_seen = 0;
        pulse_start();
        repeat (24) cycle();
        chk("wrap_data", int'(data), 1);
        chk("wrap_dones", n_done_seen, 1);

        // Pause mid-run, release, then stop+load together.
        limit = 8'h80;
        pulse_load(0);
        pulse_start();
        repeat (6) cycle();
        pause = 1;
        cycle();
        n_tick_seen = 0;
        repeat (9) cycle();
        chk("pause_ticks", n_tick_seen, 0);
        chk("pause_busy", int'(busy), 1);
        pause = 0;
        repeat (8) cycle();
        stop = 1; load = 1; load_val = 8'h77;
        cycle();
        stop = 0; load = 0;
        chk("stopload_busy", int'(busy), 0);
        chk("stopload_data", int'(data), m_data);
        // reload value must survive: finish a one-shot and restart from DONE.
        limit = W'(m_data + 1);
        pulse_start();
        repeat (12) cycle();
        pulse_start();
        cycle();
        chk("reload_kept", int'(data), 0);
        pulse_stop();

`ifdef CNTSEQ_DOWN_EN
        // Down count 0x01 -> 0xFE with dir toggled mid-run.
        limit = 8'hFE; auto_reload = 0;
        pulse_load(1);
        dir = 1;
        n_done_seen = 0;
        pulse_start();
        repeat (6) cycle();
        dir = 0;
        repeat (18) cycle();
        chk("down_data", int'(data), 8'hFE);
        chk("down_dones", n_done_seen, 1);
        pulse_stop();
`endif

        // Randomized commands against the model.
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stop        = ($urandom_range(0, 59) == 0);
            load        = ($urandom_range(0, 24) == 0);
            start       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
            load_val    = W'(8'hFC + $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) limit = W'(8'hFC + $urandom_range(0, 7));
`ifdef CNTSEQ_DOWN_EN
            dir         = $urandom_range(0, 1) != 0;
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
